// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall vector
// layout, canned stall patterns, controller states and reset level.
package pipeline_ctrl_pkg;

  localparam int unsigned STALL_W   = 6;
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic [STALL_W-1:0] StallNone     = 6'b000000;
  localparam logic [STALL_W-1:0] StallIdBubble = 6'b000111;
  localparam logic [STALL_W-1:0] StallExHold   = 6'b001111;

  localparam logic RstActive = 1'b0;

  typedef enum logic [1:0] {
    CtrlIdle   = 2'd0,
    CtrlMcBusy = 2'd1,
    CtrlFlush  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: per-stage stall vector, multi-cycle EX
// sequencing and registered flush/redirect generation.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MC_CNT_W  = 6,
  parameter int unsigned FLUSH_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_busy,
  output logic                mc_done
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_LEN);

  ctrl_state_e         r_state;
  logic [MC_CNT_W-1:0] r_cnt;
  logic [1:0]          r_fcnt;
  logic                r_flush;
  logic [31:0]         r_new_pc;

  logic       w_in_rst;
  logic       w_flush_act;
  logic       w_mc_hold;
  logic       w_mc_valid;
  logic       w_mc_one;
  logic [5:0] w_stall;
  logic       w_mc_done;

  assign w_in_rst    = (rst == RstActive);
  assign w_mc_valid  = (mc_cycles != '0);
  assign w_mc_one    = (mc_cycles == MC_CNT_W'(1));
  assign w_flush_act = flush_req || (r_state == CtrlFlush);
  assign w_mc_hold   = (r_state == CtrlMcBusy) ||
                       ((r_state == CtrlIdle) && mc_start && w_mc_valid);

  // Outputs are forced quiet while reset is held, even with live inputs.
  always_comb begin
    w_stall   = StallNone;
    w_mc_done = 1'b0;
    if (!w_in_rst && !w_flush_act) begin
      if (w_mc_hold)        w_stall = StallExHold;
      else if (stallreq_id) w_stall = StallIdBubble;
      w_mc_done = ((r_state == CtrlIdle) && mc_start && w_mc_one) ||
                  ((r_state == CtrlMcBusy) && (r_cnt == MC_CNT_W'(1)));
    end
  end

  // A flush request overrides every state, so it is handled ahead of the case.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      r_state  <= CtrlIdle;
      r_cnt    <= '0;
      r_fcnt   <= '0;
      r_flush  <= 1'b0;
      r_new_pc <= '0;
    end else if (flush_req) begin
      r_state  <= CtrlFlush;
      r_cnt    <= '0;
      r_fcnt   <= FLUSH_LOAD;
      r_flush  <= 1'b1;
      r_new_pc <= flush_pc;
    end else begin
      case (r_state)
        CtrlIdle: begin
          if (mc_start && (mc_cycles >= MC_CNT_W'(2))) begin
            r_state <= CtrlMcBusy;
            r_cnt   <= mc_cycles - MC_CNT_W'(1);
          end
        end
        CtrlMcBusy: begin
          if (r_cnt == MC_CNT_W'(1)) begin
            r_state <= CtrlIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - MC_CNT_W'(1);
          end
        end
        CtrlFlush: begin
          if (r_fcnt == 2'd1) begin
            r_state <= CtrlIdle;
            r_fcnt  <= '0;
            r_flush <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - 2'd1;
          end
        end
        default: begin
          r_state <= CtrlIdle;
          r_cnt   <= '0;
          r_fcnt  <= '0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign stall   = w_stall;
  assign flush   = r_flush;
  assign new_pc  = r_new_pc;
  assign mc_busy = !w_in_rst && (r_state == CtrlMcBusy);
  assign mc_done = w_mc_done;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// traffic, all checked against a remaining-cycles reference model.
module tb_pipeline_ctrl;

  localparam int unsigned MC_W = 6;
  localparam int unsigned FL   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stallreq_id = 1'b0;
  logic            mc_start = 1'b0;
  logic [MC_W-1:0] mc_cycles = '0;
  logic            flush_req = 1'b0;
  logic [31:0]     flush_pc = '0;
  logic [5:0]      stall;
  logic            flush;
  logic [31:0]     new_pc;
  logic            mc_busy;
  logic            mc_done;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles of multi-cycle work left after the current one,
  // cycles of flush output left, and the most recent redirect target.
  int          m_mc_left    = 0;
  int          m_flush_left = 0;
  logic [31:0] m_new_pc     = '0;

  pipeline_ctrl #(.MC_CNT_W(MC_W), .FLUSH_LEN(FL)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .mc_busy(mc_busy),
    .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ms, input int mcn,
                       input logic fr, input logic [31:0] fpc);
    stallreq_id = st;
    mc_start    = ms;
    mc_cycles   = MC_W'(mcn);
    flush_req   = fr;
    flush_pc    = fpc;
  endtask

  task automatic model_reset();
    m_mc_left    = 0;
    m_flush_left = 0;
    m_new_pc     = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/stall"},   32'(stall),   32'd0);
    chk({tag, "/flush"},   32'(flush),   32'd0);
    chk({tag, "/new_pc"},  new_pc,       32'd0);
    chk({tag, "/mc_busy"}, 32'(mc_busy), 32'd0);
    chk({tag, "/mc_done"}, 32'(mc_done), 32'd0);
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle(input string tag);
    logic [5:0] e_stall;
    logic       e_done;
    bit         fa, busy;
    @(negedge clk);
    busy = (m_mc_left > 0);
    fa   = flush_req || (m_flush_left > 0);
    assert (!(busy && mc_start)) else $fatal(1, "FAIL protocol mc_start while busy");
    e_stall = 6'b000000;
    e_done  = 1'b0;
    if (!fa) begin
      if (busy || (mc_start && mc_cycles != 0)) e_stall = 6'b001111;
      else if (stallreq_id)                      e_stall = 6'b000111;
      e_done = busy ? (m_mc_left == 1) : (mc_start && mc_cycles == 1);
    end
    chk({tag, "/stall"},   32'(stall),   32'(e_stall));
    chk({tag, "/mc_done"}, 32'(mc_done), 32'(e_done));
    chk({tag, "/mc_busy"}, 32'(mc_busy), 32'(busy));
    chk({tag, "/flush"},   32'(flush),   32'(m_flush_left > 0));
    if (m_flush_left > 0) chk({tag, "/new_pc"}, new_pc, m_new_pc);
    @(posedge clk);
    if (flush_req) begin
      m_flush_left = FL;
      m_new_pc     = flush_pc;
      m_mc_left    = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_mc_left > 0) begin
      m_mc_left--;
    end else if (mc_start && mc_cycles >= 2) begin
      m_mc_left = int'(mc_cycles) - 1;
    end
    #1;
  endtask

  initial begin
    // Reset held with live requests on every input.
    drive(1'b1, 1'b1, 4, 1'b1, 32'hdead_beef);
    repeat (3) begin
      @(negedge clk);
      chk_quiet("reset_hold");
    end
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cycle("post_reset_idle");

    // Load-use stall for two cycles.
    drive(1'b1, 1'b0, 0, 1'b0, 32'h0);
    cycle("id_stall_1");
    cycle("id_stall_2");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    cycle("id_stall_off");

    // Multi-cycle lengths 4, 1 and 0.
    drive(1'b0, 1'b1, 4, 1'b0, 32'h0);
    cycle("mc4_c1");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    cycle("mc4_c2");
    cycle("mc4_c3");
    cycle("mc4_c4");
    cycle("mc4_c5");
    drive(1'b0, 1'b1, 1, 1'b0, 32'h0);
    cycle("mc1_c1");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    cycle("mc1_c2");
    drive(1'b0, 1'b1, 0, 1'b0, 32'h0);
    cycle("mc0_c1");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    cycle("mc0_c2");

    // Flush aborting a 10-cycle op in its third busy cycle.
    drive(1'b0, 1'b1, 10, 1'b0, 32'h0);
    cycle("abort_start");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    cycle("abort_busy1");
    cycle("abort_busy2");
    drive(1'b0, 1'b0, 0, 1'b1, 32'h0000_0100);
    cycle("abort_busy3_flush");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    repeat (FL + 1) cycle("abort_flush");

    // Flush beats mc_start and stallreq_id; second request relatches.
    drive(1'b1, 1'b1, 5, 1'b1, 32'h0000_0200);
    cycle("combo_req");
    drive(1'b0, 1'b0, 0, 1'b1, 32'h0000_0300);
    cycle("combo_flush_relatch");
    drive(1'b1, 1'b1, 3, 1'b0, 32'h0);
    repeat (FL) cycle("combo_flush_ext");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    cycle("combo_idle");

    // Asynchronous reset dropped mid-op between clock edges.
    drive(1'b0, 1'b1, 6, 1'b0, 32'h0);
    cycle("areset_start");
    drive(1'b1, 1'b0, 0, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1 chk_quiet("areset_immediate");
    @(posedge clk); #1;
    chk_quiet("areset_held");
    model_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3, 1'b0, 32'h0);
    cycle("post_areset_mc3_c1");
    drive(1'b0, 1'b0, 0, 1'b0, 32'h0);
    cycle("post_areset_mc3_c2");
    cycle("post_areset_mc3_c3");
    cycle("post_areset_mc3_c4");

    // Random traffic; mc_start only offered when no op is in flight.
    for (int i = 0; i < 400; i++) begin
      logic ms;
      ms = (m_mc_left == 0) && ($urandom_range(3) == 0);
      drive(($urandom_range(2) == 0), ms, int'($urandom_range(7)),
            ($urandom_range(7) == 0), $urandom);
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Generates the per-stage stall vector that drives the hold/bubble behaviour of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences multi-cycle EX operations (mult/div) with a down-counter, and issues a registered flush plus redirect PC on branch/exception.
- Arbitrates simultaneous stall sources; sits beside the pipeline registers at top level.

Parameters:
- MC_CNT_W, 6, width of the multi-cycle length input and internal counter (max 63 cycles).
- FLUSH_LEN, 1, cycles flush stays asserted per flush request (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- stallreq_id  in  1  ID load-use hazard; level, evaluated every cycle.
- mc_start  in  1  EX starting a multi-cycle op this cycle; 1-cycle pulse.
- mc_cycles  in  MC_CNT_W  total EX cycles the op occupies; sampled with mc_start.
- flush_req  in  1  branch/exception redirect request; 1-cycle pulse.
- flush_pc  in  32  redirect target; sampled with flush_req.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; combinational.
- flush  out  1  registered; pipeline registers load NOP while high.
- new_pc  out  32  registered redirect target; valid while flush=1.
- mc_busy  out  1  state==MC_BUSY.
- mc_done  out  1  high in the final cycle of a multi-cycle op (EX result valid); combinational.

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0, flush=0, new_pc=0; stall, mc_busy and mc_done forced to 0 while rst=0.
- States: IDLE, MC_BUSY, FLUSH. Registered state; stall and mc_done are combinational from state, counter and inputs.
- Stall priority, highest first:
  1. Flush active (flush_req=1 or state==FLUSH) -> stall=6'b000000.
  2. Multi-cycle hold, i.e. MC_BUSY, or IDLE with mc_start and mc_cycles>=1 -> stall=6'b001111 (PC..EX held, EX/MEM gets bubble).
  3. stallreq_id -> stall=6'b000111 (PC..ID held, ID/EX gets bubble).
  4. Otherwise 6'b000000.
- IDLE:
  - flush_req -> FLUSH; latch flush_pc into new_pc; flush counter = FLUSH_LEN.
  - Else mc_start with mc_cycles>=2 -> MC_BUSY; cnt = mc_cycles-1.
  - mc_start with mc_cycles==1: stall for that cycle only, mc_done=1, stay IDLE.
  - mc_cycles==0: mc_start ignored, no stall, no mc_done.
- MC_BUSY:
  - cnt decrements each cycle. When cnt==1: mc_done=1, next state IDLE.
  - Total stall length equals mc_cycles, counting the mc_start cycle.
  - mc_start while busy is ignored (protocol violation; bench asserts it never occurs).
  - flush_req aborts: -> FLUSH; cnt cleared; mc_done not asserted; stall=0 that cycle.
- FLUSH:
  - flush=1 for exactly FLUSH_LEN cycles, starting the cycle after flush_req.
  - Then -> IDLE, flush=0 on the following edge.
  - A new flush_req in FLUSH relatches new_pc and reloads the flush counter (last request wins).
  - mc_start and stallreq_id are ignored in FLUSH.
- Simultaneous flush_req and mc_start in IDLE: flush wins, and the multi-cycle op is discarded.
- Reset asserted mid-operation: immediate return to reset values; no mc_done pulse and no flush is emitted.

Decomposition:
- Shared defines header (extend the existing one):
  - Stall bit indices, and StallNone=6'b000000, StallIdBubble=6'b000111, StallExHold=6'b001111.
  - State encodings CtrlIdle, CtrlMcBusy, CtrlFlush.
  - Active-low reset-level macro.
- No sub-module. The multi-cycle counter and flush counter are simple and stay inline.

Test Plan:
- Reset with mc_start=1, flush_req=1 held for 3 cycles -> stall=0, flush=0, new_pc=0, mc_busy=0 throughout; IDLE after release.
- stallreq_id=1 for 2 cycles in IDLE -> stall=6'b000111 in exactly those cycles, 0 after; flush stays 0.
- mc_start with mc_cycles=4 -> stall=6'b001111 for 4 consecutive cycles (including the start cycle), mc_busy high in cycles 2-4, mc_done only in cycle 4; stall=0 in cycle 5. Repeat with mc_cycles=1 -> 1 stall cycle with mc_done; mc_cycles=0 -> no effect.
- mc_start with mc_cycles=10, flush_req with flush_pc=32'h0000_0100 in the 3rd busy cycle -> stall=0 that cycle, flush=1 next cycle with new_pc=32'h100, no mc_done, mc_busy=0.
- Same-cycle flush_req (flush_pc=32'h200) + mc_start + stallreq_id in IDLE -> stall=0, flush=1 next cycle with new_pc=32'h200; FLUSH_LEN=2 build: flush high for exactly 2 cycles; second flush_req (32'h300) during FLUSH -> new_pc=32'h300 and flush extended by 2 cycles.
- Async rst dropped mid-MC_BUSY (cnt=5) between clock edges -> stall, mc_busy=0 immediately; after release, mc_start with mc_cycles=3 runs a clean 3-cycle hold.
